// File: rtl/sprite_mask_pkg.sv
// Shared constants and FSM state type for the sprite mask fetch arbiter.
package sprite_mask_pkg;

    localparam int unsigned ADDR_W  = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned COL_W   = 5;
    localparam int unsigned ROW_W   = 5;
    localparam int unsigned ROW_LEN = 2 ** COL_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ROW  = 2'd1,
        HOST = 2'd2
    } state_e;

endpackage

// File: rtl/sprite_mask_fetch_arbiter.sv
// Shares one single-port sprite mask RAM between a row-burst renderer and a host port.
// Optional build macro SPRITE_MASK_MIRROR_EN adds row_mirror for horizontally flipped fetches.
module sprite_mask_fetch_arbiter
    import sprite_mask_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              row_req,
    input  logic [ROW_W-1:0]  row_idx,
`ifdef SPRITE_MASK_MIRROR_EN
    input  logic              row_mirror,
`endif
    output logic              row_ack,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [COL_W-1:0]  pix_col,
    output logic              row_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_LEN - 1);

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic               mirror_q, mirror_d;
    logic               host_turn_q, host_turn_d;
    logic               mirror_in;

`ifdef SPRITE_MASK_MIRROR_EN
    assign mirror_in = row_mirror;
`else
    assign mirror_in = 1'b0;
`endif

    // State and sequencing registers; pixel/read-return outputs trail the RAM issue by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            mirror_q    <= 1'b0;
            host_turn_q <= 1'b0;
            pix_valid   <= 1'b0;
            pix_col     <= '0;
            row_done    <= 1'b0;
            host_rvalid <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            mirror_q    <= mirror_d;
            host_turn_q <= host_turn_d;
            pix_valid   <= (state_q == ROW);
            pix_col     <= col_q;
            row_done    <= (state_q == ROW) && (col_q == COL_LAST);
            host_rvalid <= host_gnt && !host_we;
        end
    end

    // Arbitration, next state and RAM port drive; all suppressed while reset is held.
    always_comb begin
        state_d         = state_q;
        col_d           = col_q;
        row_d           = row_q;
        mirror_d        = mirror_q;
        host_turn_d     = host_turn_q;
        row_ack         = 1'b0;
        host_gnt        = 1'b0;
        mem_address     = '0;
        mem_chipselect  = 1'b0;
        mem_write       = 1'b0;
        mem_debugaccess = 1'b0;
        mem_writedata   = '0;

        if (!reset) begin
            case (state_q)
                IDLE: begin
                    if (host_req && (!row_req || host_turn_q)) begin
                        host_gnt        = 1'b1;
                        mem_address     = host_addr;
                        mem_chipselect  = 1'b1;
                        mem_write       = host_we;
                        mem_debugaccess = host_we;
                        mem_writedata   = host_wdata;
                        host_turn_d     = 1'b0;
                        state_d         = HOST;
                    end else if (row_req) begin
                        row_ack  = 1'b1;
                        row_d    = row_idx;
                        mirror_d = mirror_in;
                        col_d    = '0;
                        state_d  = ROW;
                    end
                end
                ROW: begin
                    // Mirrored rows walk the RAM columns in reverse: 31-col is ~col at this width.
                    mem_address    = {row_q, col_q ^ {COL_W{mirror_q}}};
                    mem_chipselect = 1'b1;
                    col_d          = col_q + COL_W'(1);
                    if (col_q == COL_LAST) begin
                        state_d = IDLE;
                        if (host_req) begin
                            host_turn_d = 1'b1;
                        end
                    end
                end
                HOST: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign pix_data   = pix_valid ? mem_readdata : '0;
    assign host_rdata = host_rvalid ? mem_readdata : '0;
    assign mem_clken  = 1'b1;

endmodule
